vga_timing_rx: RTL

- Receive-side counterpart of the VGA timing generator: samples a 640x480@60 VGA stream (hsync, vsync, 4-bit RGB) on the pixel clock.
- Measures line period and frame height, and locks onto the expected timing.
- Recovers per-pixel x/y coordinates and a data-enable signal.
- Used for loopback self-test of the display path and as the front end for frame-capture and checking logic.

---
 rtl/vga_timing_rx.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_rx.sv
// ----------------------------------------------------------------------------
// vga_timing_rx
//
// Receive side of the VGA path. It samples an incoming hsync/vsync/RGB stream
// on the pixel clock and measures the line period and the frame height. Once
// enough consecutive frames match the expected timing, it reports lock and
// produces per-pixel coordinates and a data-enable. Loopback self-test and
// frame-capture logic consume these outputs.
//
// Ports
//   clk_i          pixel clock
//   reset_i        asynchronous, active-high reset
//   hsync_i        horizontal sync (polarity set by SYNC_ACTIVE_LOW)
//   vsync_i        vertical sync   (polarity set by SYNC_ACTIVE_LOW)
//   red_i/green_i/blue_i   4-bit pixel colour in
//   red_o/green_o/blue_o   4-bit pixel colour out, zero outside de_o
//   x_o, y_o       visible column/row, zero outside de_o
//   de_o           visible pixel while locked
//   frame_start_o  one-cycle pulse per vsync assert edge
//   h_period_o     last measured line length in clocks
//   v_lines_o      last measured frame length in lines
//   locked_o       timing lock
//
// Latency: a pixel registered at clock edge N appears on the colour, x_o,
// y_o and de_o outputs at edge N+2.
// ----------------------------------------------------------------------------
module vga_timing_rx #(
    parameter int H_TOTAL          = 800,
    parameter int V_TOTAL          = 525,
    parameter int H_VISIBLE        = 640,
    parameter int V_VISIBLE        = 480,
    parameter int H_SYNC_TO_ACTIVE = 144,
    parameter int V_SYNC_TO_ACTIVE = 35,
    parameter bit SYNC_ACTIVE_LOW  = 1'b1,
    parameter int LOCK_FRAMES      = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic [3:0]  red_i,
    input  logic [3:0]  green_i,
    input  logic [3:0]  blue_i,
    output logic [3:0]  red_o,
    output logic [3:0]  green_o,
    output logic [3:0]  blue_o,
    output logic [9:0]  x_o,
    output logic [9:0]  y_o,
    output logic        de_o,
    output logic        frame_start_o,
    output logic [11:0] h_period_o,
    output logic [10:0] v_lines_o,
    output logic        locked_o
);

    localparam logic [11:0] H_MAX = 12'hFFF;
    localparam logic [10:0] V_MAX = 11'h7FF;

    // good_cnt only ever holds 0..LOCK_FRAMES-1; reaching the last value
    // together with another good frame is what moves the FSM to LOCKED.
    localparam int GW = (LOCK_FRAMES > 2) ? $clog2(LOCK_FRAMES) : 1;
    localparam logic [GW-1:0] LAST_GOOD = GW'(LOCK_FRAMES - 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    // Input stage: syncs are stored already normalised to "1 = asserted".
    logic        hs_q, vs_q, hs_prev_q, vs_prev_q;
    logic [11:0] rgb_q;

    // Measurement state
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        h_valid_q, v_valid_q, line_err_q;

    // Lock FSM
    state_t      state_q;
    logic [GW-1:0] good_cnt_q;

    // Pixel pipeline stage between the input register and the outputs
    logic [11:0] pix2_q;
    logic        vis2_q;
    logic [9:0]  x2_q, y2_q;

    // Combinational helpers
    logic        hs_edge, vs_edge;
    logic [11:0] h_inc;
    logic [12:0] h_len;
    logic [10:0] v_inc;
    logic [11:0] v_cap;
    logic        bad_line, frame_good, frame_bad;
    logic        go_lock, drop_lock, lock_next;
    logic [12:0] pos_k;
    logic [11:0] pos_j;
    logic        visible;
    logic [9:0]  x_d, y_d;

    // Register every input once; the previous sync values give the edges.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            rgb_q     <= '0;
        end else begin
            hs_q      <= hsync_i ^ SYNC_ACTIVE_LOW;
            vs_q      <= vsync_i ^ SYNC_ACTIVE_LOW;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
            rgb_q     <= {red_i, green_i, blue_i};
        end
    end

    assign hs_edge = hs_q & ~hs_prev_q;
    assign vs_edge = vs_q & ~vs_prev_q;

    // h_len is the line length ending at an hsync edge (h_cnt+1, unsaturated).
    // v_cap is the line count a vsync edge would capture, counting an hsync
    // edge that lands in the same cycle.
    always_comb begin
        h_inc = (h_cnt_q == H_MAX) ? H_MAX : h_cnt_q + 12'd1;
        h_len = {1'b0, h_cnt_q} + 13'd1;
        v_inc = (v_cnt_q == V_MAX) ? V_MAX : v_cnt_q + 11'd1;
        v_cap = hs_edge ? ({1'b0, v_cnt_q} + 12'd1) : {1'b0, v_cnt_q};

        h_cnt_d = hs_edge ? 12'd0 : h_inc;
        v_cnt_d = v_cnt_q;
        if (vs_edge) begin
            v_cnt_d = 11'd0;
        end else if (hs_edge) begin
            v_cnt_d = v_inc;
        end
    end

    // A bad line in the same cycle as the vsync edge still spoils the frame.
    assign bad_line   = hs_edge & h_valid_q & (h_len != 13'(H_TOTAL));
    assign frame_good = vs_edge & v_valid_q & (v_cap == 12'(V_TOTAL))
                        & ~line_err_q & ~bad_line;
    assign frame_bad  = vs_edge & ~frame_good;

    // The first hsync edge after reset only starts a measurement, so
    // h_period_o stays 0 until a complete line has been seen.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            h_valid_q     <= 1'b0;
            v_valid_q     <= 1'b0;
            line_err_q    <= 1'b0;
            h_period_o    <= '0;
            v_lines_o     <= '0;
            frame_start_o <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_o <= vs_edge;
            if (hs_edge) begin
                h_valid_q <= 1'b1;
                if (h_valid_q) begin
                    h_period_o <= h_inc;
                end
            end
            if (vs_edge) begin
                v_valid_q  <= 1'b1;
                v_lines_o  <= hs_edge ? v_inc : v_cnt_q;
                line_err_q <= 1'b0;
            end else if (bad_line) begin
                line_err_q <= 1'b1;
            end
        end
    end

    // Lock decisions are made combinationally so de_o can follow locked_o
    // in the very same cycle.
    assign go_lock   = (state_q == UNLOCKED) & frame_good & (good_cnt_q == LAST_GOOD);
    assign drop_lock = (state_q == LOCKED) &
                       (bad_line | frame_bad | (h_cnt_q == H_MAX) | (v_cnt_q == V_MAX));
    assign lock_next = (state_q == LOCKED) ? ~drop_lock : go_lock;

    // Lock FSM with registered locked_o.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= UNLOCKED;
            good_cnt_q <= '0;
            locked_o   <= 1'b0;
        end else begin
            case (state_q)
                UNLOCKED: begin
                    if (go_lock) begin
                        state_q    <= LOCKED;
                        locked_o   <= 1'b1;
                        good_cnt_q <= '0;
                    end else if (frame_good) begin
                        good_cnt_q <= good_cnt_q + GW'(1);
                    end else if (frame_bad) begin
                        good_cnt_q <= '0;
                    end
                end
                LOCKED: begin
                    if (drop_lock) begin
                        state_q    <= UNLOCKED;
                        locked_o   <= 1'b0;
                        good_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q    <= UNLOCKED;
                    locked_o   <= 1'b0;
                    good_cnt_q <= '0;
                end
            endcase
        end
    end

    // Position of the pixel currently in rgb_q: k clocks after the
    // hsync-assert sample, j lines after the vsync-assert line. On an edge
    // cycle the counters have not cleared yet, so the edge forces k/j.
    always_comb begin
        pos_k   = hs_edge ? 13'd0 : h_len;
        pos_j   = vs_edge ? 12'd0 : v_cap;
        visible = (pos_k >= 13'(H_SYNC_TO_ACTIVE)) &&
                  (pos_k <  13'(H_SYNC_TO_ACTIVE + H_VISIBLE)) &&
                  (pos_j >= 12'(V_SYNC_TO_ACTIVE)) &&
                  (pos_j <  12'(V_SYNC_TO_ACTIVE + V_VISIBLE));
        x_d     = 10'(pos_k - 13'(H_SYNC_TO_ACTIVE));
        y_d     = 10'(pos_j - 12'(V_SYNC_TO_ACTIVE));
    end

    // Second pipeline stage: colour and coordinates travel together.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pix2_q <= '0;
            vis2_q <= 1'b0;
            x2_q   <= '0;
            y2_q   <= '0;
        end else begin
            pix2_q <= rgb_q;
            vis2_q <= visible;
            x2_q   <= x_d;
            y2_q   <= y_d;
        end
    end

    // Output stage: everything is blanked unless the pixel is visible and
    // the receiver is locked in this same cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            de_o    <= 1'b0;
            red_o   <= '0;
            green_o <= '0;
            blue_o  <= '0;
            x_o     <= '0;
            y_o     <= '0;
        end else begin
            de_o <= vis2_q & lock_next;
            if (vis2_q & lock_next) begin
                {red_o, green_o, blue_o} <= pix2_q;
                x_o                      <= x2_q;
                y_o                      <= y2_q;
            end else begin
                {red_o, green_o, blue_o} <= '0;
                x_o                      <= '0;
                y_o                      <= '0;
            end
        end
    end

endmodule
